// File: rtl/multiplier_pipe_collect.sv
// Collects finished products from the last shift-add multiplier cell into a FIFO
// and issues launch credits so every in-flight product is guaranteed a slot.
module multiplier_pipe_collect #(
  parameter  int DW    = 4,
  parameter  int RW    = DW + DW,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_vld,
  output logic          issue_ok,
  input  logic          res_vld,
  input  logic [RW-1:0] res_data,
  output logic          m_vld,
  input  logic          m_rdy,
  output logic [RW-1:0] m_data,
  output logic [CW-1:0] level,
  output logic          busy,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);

  logic [RW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_level;
  logic [CW-1:0] r_inflight;
  logic          r_err;

  logic          w_push;
  logic          w_pop;
  logic          w_take;
  logic          w_ret;
  logic [CW:0]   w_sum;

  assign w_pop  = m_vld && m_rdy;
  assign w_push = res_vld && ((r_level < CW'(DEPTH)) || w_pop);
  assign w_take = issue_vld && issue_ok;
  assign w_ret  = res_vld && (r_inflight != '0);

  // One extra bit so level + inflight can never wrap before the compare.
  assign w_sum    = {1'b0, r_level} + {1'b0, r_inflight};
  assign issue_ok = !rst && (w_sum < (CW+1)'(DEPTH));

  assign m_vld  = (r_level != '0);
  assign m_data = m_vld ? r_mem[r_rd_ptr] : '0;
  assign level  = r_level;
  assign busy   = (r_level != '0) || (r_inflight != '0);
  assign err    = r_err;

  // NOTE: storage is deliberately not reset; occupancy alone decides what is
  // valid, and leaving the array reset-free lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= res_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of its neighbours, matching real flop behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + CW'(1);
        2'b01:   r_level <= r_level - CW'(1);
        default: r_level <= r_level;
      endcase

      case ({w_take, w_ret})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase

      // Sticky: uncredited issue, product with no credit, or dropped product.
      if ((issue_vld && !issue_ok) ||
          (res_vld && (r_inflight == '0)) ||
          (res_vld && !w_push))
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multiplier_pipe_collect.sv
// Directed bench for multiplier_pipe_collect: reset, single product, credits,
// full push/pop, protocol errors, mid-operation reset and a streaming wrap run.
module tb_multiplier_pipe_collect;

  localparam int DW    = 4;
  localparam int RW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_vld;
  logic          issue_ok;
  logic          res_vld;
  logic [RW-1:0] res_data;
  logic          m_vld;
  logic          m_rdy;
  logic [RW-1:0] m_data;
  logic [CW-1:0] level;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplier_pipe_collect #(.DW(DW), .RW(RW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .issue_vld(issue_vld),
    .issue_ok (issue_ok),
    .res_vld  (res_vld),
    .res_data (res_data),
    .m_vld    (m_vld),
    .m_rdy    (m_rdy),
    .m_data   (m_data),
    .level    (level),
    .busy     (busy),
    .err      (err)
  );

  // Advance one edge and sample 1 ns later, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    issue_vld = 1'b0; res_vld = 1'b0; res_data = '0; m_rdy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      issue_vld = 1'b1;
      step();
    end
    issue_vld = 1'b0;
  endtask

  task automatic test_reset();
    issue_vld = 1'b0; res_vld = 1'b0; res_data = '0; m_rdy = 1'b1;
    rst = 1'b1;
    step();
    step();
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL reset_issue_ok got %b exp 0", issue_ok); end
    checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL reset_m_vld got %b exp 0", m_vld); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b0;
    #1;
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL release_issue_ok got %b exp 1", issue_ok); end
  endtask

  task automatic test_single();
    do_reset();
    m_rdy = 1'b1;
    issue_n(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_inflight got %b exp 1", busy); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_level0 got %0d exp 0", level); end
    res_vld = 1'b1; res_data = 8'h2D;
    step();
    res_vld = 1'b0; res_data = '0;
    checks++; if (m_vld !== 1'b1) begin errors++; $display("FAIL single_m_vld got %b exp 1", m_vld); end
    checks++; if (m_data !== 8'h2D) begin errors++; $display("FAIL single_m_data got %h exp 2d", m_data); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level1 got %0d exp 1", level); end
    step();
    checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %b exp 0", m_vld); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_level_back got %0d exp 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", err); end
  endtask

  // Also leaves the FIFO full with 0x11..0x18 for test_full_pushpop.
  task automatic test_credit();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL credit_ok_before_take%0d got %b exp 1", i, issue_ok); end
      issue_vld = 1'b1;
      step();
    end
    issue_vld = 1'b0;
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL credit_ok_after_8 got %b exp 0", issue_ok); end
    for (int i = 0; i < DEPTH; i++) begin
      res_vld = 1'b1; res_data = 8'h10 + 8'(i);
      step();
      checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL credit_ok_low_res%0d got %b exp 0", i, issue_ok); end
    end
    res_vld = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL credit_level8 got %0d exp 8", level); end
    checks++; if (m_data !== 8'h10) begin errors++; $display("FAIL credit_head got %h exp 10", m_data); end
    m_rdy = 1'b1;
    step();
    m_rdy = 1'b0;
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL credit_ok_return got %b exp 1", issue_ok); end
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL credit_level7 got %0d exp 7", level); end
    issue_n(1);
    checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL credit_ok_refill got %b exp 0", issue_ok); end
    res_vld = 1'b1; res_data = 8'h18;
    step();
    res_vld = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL credit_refull got %0d exp 8", level); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL credit_err got %b exp 0", err); end
  endtask

  task automatic test_full_pushpop();
    checks++; if (m_data !== 8'h11) begin errors++; $display("FAIL full_head got %h exp 11", m_data); end
    res_vld = 1'b1; res_data = 8'h19; m_rdy = 1'b1;
    step();
    res_vld = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_level_hold got %0d exp 8", level); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (m_data !== 8'h12 + 8'(i)) begin errors++; $display("FAIL full_order%0d got %h exp %h", i, m_data, 8'h12 + 8'(i)); end
      step();
    end
    checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", m_vld); end
    m_rdy = 1'b0;
  endtask

  task automatic test_protocol_err();
    do_reset();
    issue_n(DEPTH);
    issue_vld = 1'b1;
    step();
    issue_vld = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_issue_err got %b exp 1", err); end
    for (int i = 0; i < DEPTH; i++) begin
      res_vld = 1'b1; res_data = 8'h40 + 8'(i);
      step();
    end
    res_vld = 1'b0;
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL perr_level got %0d exp 8", level); end
    m_rdy = 1'b1;
    step();
    m_rdy = 1'b0;
    // Inflight stayed at 8, so one pop leaves level+inflight at 7.
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL perr_inflight_unchanged got %b exp 1", issue_ok); end

    do_reset();
    res_vld = 1'b1; res_data = 8'h5A;
    step();
    res_vld = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_nocredit_err got %b exp 1", err); end
    checks++; if (m_vld !== 1'b1) begin errors++; $display("FAIL perr_nocredit_vld got %b exp 1", m_vld); end
    checks++; if (m_data !== 8'h5A) begin errors++; $display("FAIL perr_nocredit_data got %h exp 5a", m_data); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    issue_n(DEPTH);
    for (int i = 0; i < 5; i++) begin
      res_vld = 1'b1; res_data = 8'h70 + 8'(i);
      step();
    end
    res_vld = 1'b0;
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_level5 got %0d exp 5", level); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL mid_level got %0d exp 0", level); end
    checks++; if (m_vld !== 1'b0) begin errors++; $display("FAIL mid_m_vld got %b exp 0", m_vld); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", err); end
    checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL mid_issue_ok got %b exp 1", issue_ok); end
  endtask

  // 4-stage pipeline model feeds products; scoreboard checks order.
  task automatic test_streaming();
    logic          pv [4];
    logic [RW-1:0] pd [4];
    logic [RW-1:0] sb [$];
    logic [RW-1:0] exp_d;
    logic [RW-1:0] prod;
    int issued, popped, cyc, bad;
    logic [3:0] a, b;
    do_reset();
    for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    issued = 0; popped = 0; cyc = 0; bad = 0;
    while (popped < 40 && cyc < 2000) begin
      issue_vld = (issued < 40) && issue_ok;
      a = 4'(issued); b = 4'(issued * 7 + 3);
      prod = RW'(a) * RW'(b);
      res_vld  = pv[3];
      res_data = pd[3];
      m_rdy    = 1'($urandom_range(0, 1));
      if (m_vld && m_rdy) begin
        exp_d = sb.pop_front();
        if (m_data !== exp_d) begin
          bad++;
          $display("FAIL stream_data%0d got %h exp %h", popped, m_data, exp_d);
        end
        popped++;
      end
      if (res_vld) sb.push_back(res_data);
      for (int i = 3; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = issue_vld; pd[0] = prod;
      if (issue_vld) issued++;
      step();
      cyc++;
    end
    issue_vld = 1'b0; res_vld = 1'b0; m_rdy = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_scoreboard got %0d bad exp 0", bad); end
    checks++; if (popped != 40) begin errors++; $display("FAIL stream_count got %0d exp 40 (timeout)", popped); end
    checks++; if (popped / DEPTH < 4) begin errors++; $display("FAIL stream_wraps got %0d exp >=4", popped / DEPTH); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stream_err got %b exp 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_full_pushpop();
    test_protocol_err();
    test_reset_midop();
    test_streaming();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
